// File: rtl/soc_system_fpga_status_in_if.sv
// ---------------------------------------------------------------------------
// soc_system_fpga_status_in_if
//   Avalon-MM slave bus bundle for the FPGA status input PIO.
//   Ports (signals):
//     address    [1:0]  word address of register
//     chipselect        slave select
//     write_n           active-low write strobe
//     writedata  [31:0] write data
//     readdata   [31:0] read data, valid one clk after address
//   Modports: master (HPS bridge side), slave (PIO side).
// ---------------------------------------------------------------------------
interface soc_system_fpga_status_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_fpga_status_in.sv
// ---------------------------------------------------------------------------
// soc_system_fpga_status_in
//   Avalon-MM PIO input slave. WIDTH fabric status bits are synchronized into
//   clk, selected edges latch into a write-1-to-clear capture register, and a
//   maskable level interrupt is raised toward the HPS.
//
//   Register map (word address):
//     0 DATA          RO    synchronized inputs
//     1 reserved            reads 0
//     2 IRQ_MASK      RW
//     3 EDGE_CAPTURE  W1C
//
//   Ports:
//     clk      system clock
//     reset_n  asynchronous active-low reset
//     bus      Avalon-MM slave (address, chipselect, write_n, writedata,
//              readdata with fixed read latency 1)
//     in_port  asynchronous fabric status inputs [WIDTH-1:0]
//     irq      registered level interrupt
//
//   Note for driver writers: an input already high when reset releases
//   produces one rising/any edge SYNC_STAGES clks later, because the
//   synchronizer fills from 0.
// ---------------------------------------------------------------------------
module soc_system_fpga_status_in #(
  parameter int WIDTH       = 1,  // 1..32
  parameter int EDGE_TYPE   = 0,  // 0=rising, 1=falling, 2=any
  parameter int SYNC_STAGES = 2   // 2..3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  soc_system_fpga_status_in_if.slave    bus,
  input  logic [WIDTH-1:0]              in_port,
  output logic                          irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  // Synchronizer chain: stage 0 samples the pin, the top stage is sync_q.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0]                  prev_reg;
  logic [WIDTH-1:0]                  sync_q;

  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] capture_reg;
  logic [WIDTH-1:0] capture_next;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      readdata_next;
  logic             wr_en;

  assign sync_q = sync_reg[SYNC_STAGES-1];
  assign wr_en  = bus.chipselect && !bus.write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_port};
      prev_reg <= sync_q;
    end
  end

  // Edge selection is fixed at elaboration.
  generate
    if (EDGE_TYPE == 1) begin : g_falling
      assign edge_pulse = ~sync_q & prev_reg;
    end else if (EDGE_TYPE == 2) begin : g_any
      assign edge_pulse = sync_q ^ prev_reg;
    end else begin : g_rising
      assign edge_pulse = sync_q & ~prev_reg;
    end
  endgenerate

  // Writedata bits above WIDTH carry no meaning for this block.
  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata_bits;
      assign unused_wdata_bits = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  // W1C clear mask; a fresh edge in the same cycle overrides the clear so
  // no event is lost.
  assign clear_bits   = (wr_en && bus.address == ADDR_CAPTURE)
                        ? bus.writedata[WIDTH-1:0] : '0;
  assign capture_next = edge_pulse | (capture_reg & ~clear_bits);

  // Read mux uses pre-write register state; readdata is registered every
  // cycle so no read strobe is required.
  always_comb begin
    readdata_next = '0;
    case (bus.address)
      ADDR_DATA:    readdata_next[WIDTH-1:0] = sync_q;
      ADDR_MASK:    readdata_next[WIDTH-1:0] = mask_reg;
      ADDR_CAPTURE: readdata_next[WIDTH-1:0] = capture_reg;
      default:      readdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg     <= '0;
      capture_reg  <= '0;
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr_en && bus.address == ADDR_MASK) begin
        mask_reg <= bus.writedata[WIDTH-1:0];
      end
      capture_reg  <= capture_next;
      bus.readdata <= readdata_next;
      // Registered from current state: follows capture/mask changes by 1 clk.
      irq          <= |(capture_reg & mask_reg);
    end
  end

endmodule

// File: doc/soc_system_fpga_status_in.md
Name: soc_system_fpga_status_in

Overview:
Avalon-MM PIO input slave: the counterpart to the HPS-driven output bit. FPGA fabric drives WIDTH status bits, the block synchronizes them into clk, and the HPS reads them over the lightweight bridge. Selected edges on each bit latch into a capture register, which the HPS clears by writing 1s. A maskable level interrupt goes to the HPS IRQ controller.

Parameters:
WIDTH, 1, number of input status bits (1..32)
EDGE_TYPE, 0, edge that sets capture: 0=rising, 1=falling, 2=any
SYNC_STAGES, 2, synchronizer flops per bit (2..3)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  word address of register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, 1-cycle latency
in_port  in  WIDTH  asynchronous fabric status inputs
irq  out  1  level interrupt to HPS

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk. All flops (sync chain, delayed copy, irq_mask, edge_capture, readdata, irq) reset to 0.
- Synchronizer: SYNC_STAGES flops per bit. sync_q is the last stage. prev_q is sync_q delayed by one clk.
- Edge detect per bit:
  - rising: sync_q & ~prev_q
  - falling: ~sync_q & prev_q
  - any: sync_q ^ prev_q
  - A pin transition reaches sync_q after SYNC_STAGES clks. The edge pulse is valid in that same cycle.
- Register map (word address):
  - 0 DATA, RO: sync_q zero-extended to 32 bits. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQ_MASK, RW: bits [WIDTH-1:0]. Upper bits read 0.
  - 3 EDGE_CAPTURE, R/W1C: bits [WIDTH-1:0]. Writing 1 clears the bit; writing 0 has no effect.
- Write: occurs on posedge clk when chipselect && ~write_n. The register updates on that edge.
- Edge capture update per bit: next = edge_pulse | (cap & ~(w1c_hit & writedata[i])).
  - Set wins over a simultaneous clear: the captured edge is not lost.
- Read:
  - readdata is registered from address every cycle; no read strobe is needed.
  - Valid 1 clk after address is presented (fixed read latency 1).
  - Reflects register state before any write in the same cycle.
- irq: registered, = |(edge_capture & irq_mask).
  - Asserts 1 clk after the capture bit sets (mask already 1), or 1 clk after the mask is written with the capture bit already set.
  - Deasserts 1 clk after a clear or mask write removes the last active bit.
- Capture persists until W1C. Repeated edges on a set bit have no further effect; there is no counter or overflow.
- Glitch narrower than one clk may be missed. This is acceptable for status inputs.
- Reset mid-operation: all state clears immediately, irq drops asynchronously. in_port levels present at reset release do not generate an edge, because prev_q and sync_q both fill from 0.
  - Exception: a level that is already 1 at reset release produces one rising or any edge after SYNC_STAGES clks. This is intended and must be documented in the driver.
- Out-of-range bits (index >= WIDTH) of writedata are ignored.

Test Plan:
- Reset, WIDTH=4, in_port=0, read addr 0/2/3 -> readdata=0 each time; irq=0.
- in_port 0x0→0x5, SYNC_STAGES=2, EDGE_TYPE=0 -> DATA reads 0x5 from 3 clks after change; EDGE_CAPTURE=0x5; irq stays 0 (mask 0).
- Write IRQ_MASK=0x4 with capture=0x5 -> irq=1 one clk later. Write EDGE_CAPTURE=0x4 -> capture=0x1, irq=0 one clk later.
- Rising edge on bit2 in the same clk as a W1C of 0x4 -> capture bit2 remains 1; irq stays 1.
- EDGE_TYPE=1, in_port bit0 1→0 -> capture=0x1. EDGE_TYPE=2, bit0 toggles 0→1→0 with a W1C between toggles -> captured twice.
- Assert reset_n=0 mid-operation with irq=1 -> irq, mask, capture, readdata = 0 immediately. After release with in_port=0 -> no capture.
